// File: rtl/monster_engine.sv
// monster_engine: monster lifecycle (spawn, advance, kill, hero hit), game state, lives and score.
module monster_engine #(
   parameter int unsigned MONSTERS     = 12,
   parameter int unsigned LANE_W       = 2,
   parameter int unsigned STEPS        = 3,
   parameter int unsigned LIVES        = 3,
   parameter int unsigned SPAWN_THRESH = 96,
   parameter int unsigned SCORE_W      = 16,
   localparam int unsigned STEP_W      = $clog2(STEPS),
   localparam int unsigned M           = 1 + LANE_W + STEP_W
) (
   input  logic                  clk_game,
   input  logic                  rst,
   input  logic                  move_tick,
   input  logic                  start,
   input  logic                  pressing,
   input  logic [LANE_W-1:0]     state_hero,
   output logic [MONSTERS*M-1:0] state_monsters,
   output logic                  alive,
   output logic                  game_over,
   output logic [3:0]            lives_left,
   output logic [SCORE_W-1:0]    score,
   output logic                  kill_pulse,
   output logic                  hit_pulse
);
   localparam int unsigned CNT_W     = 6;
   localparam int unsigned SUM_W     = SCORE_W + CNT_W;
   localparam logic [15:0] LFSR_SEED = 16'hACE1;

   typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

   typedef struct packed {
      logic [STEP_W-1:0] step;
      logic [LANE_W-1:0] lane;
      logic              valid;
   } slot_t;

   state_t                state;
   logic                  start_q;
   logic                  start_edge;
   logic [15:0]           lfsr;
   logic                  atk_pend;
   logic [LANE_W-1:0]     atk_lane;

   logic [MONSTERS*M-1:0] tick_slots;
   logic [CNT_W-1:0]      kills;
   logic [CNT_W-1:0]      hits;
   logic [LANE_W-1:0]     spawn_lane;
   logic                  spawn;
   logic                  any_free;
   logic                  lane0_busy;
   int                    free_idx;
   slot_t                 s;
   logic [SUM_W-1:0]      score_sum;
   logic [SCORE_W-1:0]    next_score;
   logic [3:0]            next_lives;

   assign start_edge = start & ~start_q;

   // Tick datapath: judge front monsters, advance the rest, place at most one spawn.
   always_comb begin
      tick_slots = state_monsters;
      kills      = '0;
      hits       = '0;
      any_free   = 1'b0;
      lane0_busy = 1'b0;
      free_idx   = 0;
      s          = '0;
      spawn_lane = lfsr[8 +: LANE_W];
      for (int i = 0; i < int'(MONSTERS); i++) begin
         s = state_monsters[i*M +: M];
         if (!s.valid && !any_free) begin
            any_free = 1'b1;
            free_idx = i;
         end
         if (s.valid && s.step == '0 && s.lane == spawn_lane) lane0_busy = 1'b1;
         if (s.valid) begin
            if (s.step == STEP_W'(STEPS - 1)) begin
               tick_slots[i*M +: M] = '0;
               if (atk_pend && atk_lane == s.lane) kills = kills + CNT_W'(1);
               else                                hits  = hits + CNT_W'(1);
            end else begin
               tick_slots[i*M + 1 + LANE_W +: STEP_W] = s.step + STEP_W'(1);
            end
         end
      end
      spawn = (32'(lfsr[7:0]) < SPAWN_THRESH) && any_free && !lane0_busy;
      // Only slots free before the tick are eligible, so this never collides with a judged slot.
      for (int i = 0; i < int'(MONSTERS); i++) begin
         if (spawn && i == free_idx) tick_slots[i*M +: M] = {STEP_W'(0), spawn_lane, 1'b1};
      end
      score_sum  = SUM_W'(score) + SUM_W'(kills);
      next_score = (score_sum > SUM_W'({SCORE_W{1'b1}})) ? '1 : score_sum[SCORE_W-1:0];
      next_lives = (hits >= CNT_W'(lives_left)) ? 4'd0 : lives_left - 4'(hits);
   end

   // Game FSM, attack latch, LFSR and all registered outputs.
   always_ff @(posedge clk_game) begin
      if (rst) begin
         state          <= IDLE;
         alive          <= 1'b0;
         game_over      <= 1'b0;
         state_monsters <= '0;
         score          <= '0;
         lives_left     <= '0;
         kill_pulse     <= 1'b0;
         hit_pulse      <= 1'b0;
         atk_pend       <= 1'b0;
         atk_lane       <= '0;
         start_q        <= 1'b0;
         lfsr           <= LFSR_SEED;
      end else begin
         start_q    <= start;
         lfsr       <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
         kill_pulse <= 1'b0;
         hit_pulse  <= 1'b0;
         if (pressing) begin
            atk_pend <= 1'b1;
            atk_lane <= state_hero;
         end else if (move_tick) begin
            atk_pend <= 1'b0;
         end
         case (state)
            PLAY: begin
               if (move_tick) begin
                  state_monsters <= tick_slots;
                  score          <= next_score;
                  lives_left     <= next_lives;
                  kill_pulse     <= (kills != '0);
                  hit_pulse      <= (hits != '0);
                  if (next_lives == 4'd0) begin
                     state     <= OVER;
                     alive     <= 1'b0;
                     game_over <= 1'b1;
                  end
               end
            end
            default: begin
               if (start_edge) begin
                  state          <= PLAY;
                  alive          <= 1'b1;
                  game_over      <= 1'b0;
                  state_monsters <= '0;
                  score          <= '0;
                  lives_left     <= 4'(LIVES);
               end
            end
         endcase
      end
   end

endmodule

// File: doc/monster_engine.md
# monster_engine

Parametrised monster/lane engine for the FPGA Fury game core. It owns the lifecycle of every monster: spawn, advance, kill-by-attack and hero hit, plus game state, lives and score. It runs entirely in the `clk_game` domain, with monster movement gated by a one-cycle `move_tick` enable. The renderer consumes the packed per-monster state and maps lane/step to screen coordinates itself.

## Interface
Parameters:
- `MONSTERS`, 12: number of monster slots (1..32).
- `LANE_W`, 2: lane index width; `LANES = 2**LANE_W`.
- `STEPS`, 3: positions per lane; step 0 is the spawn point, step `STEPS-1` is the front (2..16).
- `STEP_W`, `$clog2(STEPS)`: derived localparam.
- `LIVES`, 3: lives granted at game start (1..15).
- `SPAWN_THRESH`, 96: spawn fires on a tick when `lfsr[7:0] < SPAWN_THRESH`.
- `SCORE_W`, 16: score counter width.

Ports:
- `clk_game`  in  1: sole clock.
- `rst`  in  1: reset, synchronous, active-high.
- `move_tick`  in  1: one-cycle movement enable.
- `start`  in  1: level; its rising edge starts a game.
- `pressing`  in  1: attack button.
- `state_hero`  in  LANE_W: lane the hero faces.
- `state_monsters`  out  MONSTERS*(1+LANE_W+STEP_W): slot i occupies bits `[i*M +: M]`, where `M = 1+LANE_W+STEP_W`; layout is {step, lane, valid} with valid at the LSB.
- `alive`  out  1: high in PLAY.
- `game_over`  out  1: high in OVER.
- `lives_left`  out  4: remaining lives.
- `score`  out  SCORE_W: kills this game, saturating.
- `kill_pulse`, `hit_pulse`  out  1 each: one-cycle event strobes.

## Operation
- FSM states:
  - IDLE → PLAY on a `start` rising edge.
  - PLAY → OVER when `lives_left` reaches 0.
  - OVER → PLAY on a `start` rising edge.
  - A `start` edge while in PLAY is ignored.
- Entering PLAY clears all slots, sets `score=0` and `lives_left=LIVES`.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11, seed 16'hACE1.
  - Steps every clock in all states; reset reseeds it.
- Attack latch:
  - Any cycle with `pressing=1` sets `atk_pend=1` and `atk_lane=state_hero`; the latest cycle wins.
  - `move_tick` clears the latch unless `pressing` is also high that cycle, in which case the new value is loaded.
  - Tick judgement always uses the pre-edge latch value.
- On `move_tick` in PLAY, evaluated from pre-tick state:
  - Front monster (step = STEPS-1): if `atk_pend` is set and `atk_lane` equals its lane, the slot is cleared, `score` increments (saturating at all-ones) and `kill_pulse` fires. Otherwise the slot is cleared, `lives_left` decrements (saturating at 0) and `hit_pulse` fires.
  - Multiple front monsters are judged independently. The attack can kill only its own lane; each other front monster costs one life in the same tick.
  - Other valid monsters: step increments by 1. A monster reaching the front is not judged until the next tick.
  - Spawn: at most one per tick, and only if all of the following hold:
    - the `lfsr[7:0] < SPAWN_THRESH` gate is true;
    - a slot was free before the tick;
    - no valid monster occupied step 0 of lane `lfsr[8 +: LANE_W]` before the tick.
  - The spawn goes into the lowest-index pre-tick free slot, at step 0 in lane `lfsr[8 +: LANE_W]`. A slot freed by this tick's judgement is not reused until the next tick.
- Outside PLAY, `move_tick` and `pressing` have no effect on slots, score or lives. Slots hold their last value in OVER, so the final frame stays visible.

## Timing
- All outputs are registered. Reset values:
  - state IDLE, `alive=0`, `game_over=0`;
  - `state_monsters=0`, `score=0`, `lives_left=0`;
  - pulses 0, `atk_pend=0`.
- Edge detection: the `start` rising edge is detected against a 1-cycle-delayed copy. `alive` rises 1 cycle after the cycle in which `start` is first sampled high.
- Tick latency: the effects of a `move_tick` sampled at edge N appear on the outputs after edge N. The pulses are high for exactly that one cycle.
- Game end: when the final life is lost on a tick, `alive` falls and `game_over` rises in that same update. The other hits and the kill from that tick are still applied.
- `rst` asserted mid-game returns to IDLE on the next edge and overrides every other input.
- `move_tick` on consecutive cycles is legal; each cycle is a full tick.

## Test plan
- Reset, then `start` 0→1: `alive=1` one cycle later, `lives_left=3`, `score=0`, `state_monsters=0`.
- `SPAWN_THRESH=256`, forced LFSR lane 2: after tick 1, slot 0 is valid with lane=2, step=0. Ticks 2 and 3 move it to step 1, then step 2; no spawn happens in lane 2 while step 0 there is occupied.
- Monster at the front of lane 2, `pressing` with `state_hero=2` held for 1 cycle before the tick: the slot clears, `score=1`, `kill_pulse` is high 1 cycle, lives stay 3.
- Same setup with `state_hero=1`: the slot clears, `lives_left=2`, `hit_pulse` is high; `pressing` asserted only in the tick cycle does not kill.
- With `LIVES=1`, two front monsters in lanes 0 and 3 and an attack on lane 0: `score=1` and `lives_left=0` in the same update, `game_over=1`, `alive=0`. Further ticks change nothing; a `start` edge restarts with `lives_left=1`.
- `rst` pulsed mid-game with 5 active slots: the next cycle shows IDLE with all outputs at their reset values, and the LFSR sequence repeats from seed.
